// File: rtl/cpu_regfile.sv
// ---------------------------------------------------------------------------
// cpu_regfile
//
// Purpose:
//   Register file and bus-fabric responder for the CPU datapath. It holds
//   NREGS registers, where R0 is the program counter. It takes the
//   controller's per-register write enables and bus output enables, and it
//   drives the three operand buses BUSA/BUSB/BUSC through priority muxes.
//   Writes can target the full word, the low byte (MOVL) or the high byte
//   (MOVH). Selecting more than one register onto one bus is flagged.
//
// Ports:
//   clk             rising-edge system clock
//   reset           synchronous, active-high reset
//   write_en        [NREGS]     bit i writes R[i] at the next rising edge
//   output_en       [3*NREGS]   bit 3i -> BUSA, 3i+1 -> BUSB, 3i+2 -> BUSC
//   wr_lane         [2]         11 word, 01 low byte, 10 high byte, 00 none
//   reg_in          [WIDTH]     write-back data
//   bus_a/b/c       [WIDTH]     operand buses
//   pc_out          [WIDTH]     current R0, always visible
//   bus_conflict    combinational multi-select flag
//   conflict_sticky registered, set by any conflicting edge, cleared by reset
//   conflict_count  [8]         (only with REGFILE_CONFLICT_CNT_EN) saturating
//                               count of edges that saw bus_conflict=1
//
// Optional feature macro: REGFILE_CONFLICT_CNT_EN
// ---------------------------------------------------------------------------
module cpu_regfile #(
  parameter int               WIDTH    = 16,
  parameter int               NREGS    = 8,
  parameter logic [WIDTH-1:0] RESET_PC = 16'h0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREGS-1:0]     write_en,
  input  logic [3*NREGS-1:0]   output_en,
  input  logic [1:0]           wr_lane,
  input  logic [WIDTH-1:0]     reg_in,
  output logic [WIDTH-1:0]     bus_a,
  output logic [WIDTH-1:0]     bus_b,
  output logic [WIDTH-1:0]     bus_c,
  output logic [WIDTH-1:0]     pc_out,
  output logic                 bus_conflict,
  output logic                 conflict_sticky
`ifdef REGFILE_CONFLICT_CNT_EN
  ,
  output logic [7:0]           conflict_count
`endif
);

  localparam logic [1:0] LANE_NONE = 2'b00;
  localparam logic [1:0] LANE_LOW  = 2'b01;
  localparam logic [1:0] LANE_HIGH = 2'b10;
  localparam logic [1:0] LANE_WORD = 2'b11;

  logic [WIDTH-1:0] regs [NREGS];

  logic [WIDTH-1:0] bus_val   [3];
  logic [2:0]       bus_hit;
  logic [2:0]       bus_multi;

  // Register array. Reset takes priority over any write in the same cycle.
  // A high-lane write puts the LOW byte of reg_in into bits [15:8], which
  // is what MOVH needs because the immediate always arrives in the low byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (i == 0) ? RESET_PC : '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (write_en[i]) begin
          case (wr_lane)
            LANE_WORD: regs[i] <= reg_in;
            LANE_LOW:  regs[i] <= {regs[i][WIDTH-1:8], reg_in[7:0]};
            LANE_HIGH: regs[i] <= {reg_in[WIDTH-9:0], regs[i][7:0]};
            LANE_NONE: regs[i] <= regs[i];
            default:   regs[i] <= regs[i];
          endcase
        end
      end
    end
  end

  // Priority bus muxes. The lowest-index selected register wins. Any later
  // select on the same bus only marks that bus as multiply driven.
  always_comb begin
    for (int b = 0; b < 3; b++) begin
      bus_val[b]   = '0;
      bus_hit[b]   = 1'b0;
      bus_multi[b] = 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        if (output_en[3*i+b]) begin
          if (bus_hit[b]) begin
            bus_multi[b] = 1'b1;
          end else begin
            bus_val[b] = regs[i];
            bus_hit[b] = 1'b1;
          end
        end
      end
    end
  end

  assign bus_a        = bus_val[0];
  assign bus_b        = bus_val[1];
  assign bus_c        = bus_val[2];
  assign pc_out       = regs[0];
  assign bus_conflict = |bus_multi;

  // Sticky conflict flag. Only reset can clear it.
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_sticky <= 1'b0;
    end else if (bus_conflict) begin
      conflict_sticky <= 1'b1;
    end
  end

`ifdef REGFILE_CONFLICT_CNT_EN
  // Saturating count of conflicting edges. It holds at 8'hFF rather than
  // wrapping, so a long-running fault can never look like a clean run.
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_count <= 8'h00;
    end else if (bus_conflict && (conflict_count != 8'hFF)) begin
      conflict_count <= conflict_count + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_regfile.sv
// ---------------------------------------------------------------------------
// tb_cpu_regfile
//
// Purpose:
//   Self-checking bench for cpu_regfile with RESET_PC=16'h0100. A behavioural
//   model is checked against the DUT on every cycle after the first reset.
//   Directed vectors also pin specific values with hand-computed constants.
//   Inputs change on the falling edge, like the real controller does.
// ---------------------------------------------------------------------------
module tb_cpu_regfile;

  localparam logic [15:0] RST_PC = 16'h0100;

  logic        clk;
  logic        reset;
  logic [7:0]  write_en;
  logic [23:0] output_en;
  logic [1:0]  wr_lane;
  logic [15:0] reg_in;
  logic [15:0] bus_a, bus_b, bus_c, pc_out;
  logic        bus_conflict, conflict_sticky;
`ifdef REGFILE_CONFLICT_CNT_EN
  logic [7:0]  conflict_count;
`endif

  int errors = 0;
  int checks = 0;

  logic [15:0] model_regs [8];
  logic        model_sticky;
  int          model_count;
  logic        model_valid = 1'b0;

  cpu_regfile #(.WIDTH(16), .NREGS(8), .RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .reset           (reset),
    .write_en        (write_en),
    .output_en       (output_en),
    .wr_lane         (wr_lane),
    .reg_in          (reg_in),
    .bus_a           (bus_a),
    .bus_b           (bus_b),
    .bus_c           (bus_c),
    .pc_out          (pc_out),
    .bus_conflict    (bus_conflict),
`ifdef REGFILE_CONFLICT_CNT_EN
    .conflict_count  (conflict_count),
`endif
    .conflict_sticky (conflict_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Builds the set of registers selected onto bus b (0=A, 1=B, 2=C).
  function automatic logic [7:0] bus_mask(input logic [23:0] oe, input int b);
    logic [7:0] m;
    for (int i = 0; i < 8; i++) m[i] = oe[3*i+b];
    return m;
  endfunction

  // Expected bus value: zero when nothing is selected, otherwise the value of
  // the lowest selected register (isolated with the m & -m trick).
  function automatic logic [15:0] model_bus(input logic [23:0] oe, input int b);
    logic [7:0] m, low;
    m = bus_mask(oe, b);
    if (m == 8'h00) return 16'h0000;
    low = m & (~m + 8'h01);
    return model_regs[$clog2(low)];
  endfunction

  function automatic logic model_conflict(input logic [23:0] oe);
    logic c;
    c = 1'b0;
    for (int b = 0; b < 3; b++) if ($countones(bus_mask(oe, b)) > 1) c = 1'b1;
    return c;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] we, input logic [23:0] oe,
                               input logic [1:0] lane, input logic [15:0] din,
                               input logic rst);
    @(negedge clk);
    write_en  = we;
    output_en = oe;
    wr_lane   = lane;
    reg_in    = din;
    reset     = rst;
  endtask

  // Model update on each rising edge, computed directly from the write rules.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) model_regs[i] <= (i == 0) ? RST_PC : 16'h0000;
      model_sticky <= 1'b0;
      model_count  <= 0;
      model_valid  <= 1'b1;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (write_en[i]) begin
          if (wr_lane == 2'b11) model_regs[i] <= reg_in;
          else if (wr_lane == 2'b01) model_regs[i] <= {model_regs[i][15:8], reg_in[7:0]};
          else if (wr_lane == 2'b10) model_regs[i] <= {reg_in[7:0], model_regs[i][7:0]};
        end
      end
      if (model_conflict(output_en)) begin
        model_sticky <= 1'b1;
        model_count  <= (model_count < 255) ? model_count + 1 : 255;
      end
    end
  end

  // Per-cycle compare, run shortly after the falling edge once inputs settle.
  always @(negedge clk) begin
    #2;
    if (model_valid) begin
      checkOutput("cmp_bus_a", bus_a, model_bus(output_en, 0));
      checkOutput("cmp_bus_b", bus_b, model_bus(output_en, 1));
      checkOutput("cmp_bus_c", bus_c, model_bus(output_en, 2));
      checkOutput("cmp_pc_out", pc_out, model_regs[0]);
      checkOutput("cmp_conflict", {15'b0, bus_conflict}, {15'b0, model_conflict(output_en)});
      checkOutput("cmp_sticky", {15'b0, conflict_sticky}, {15'b0, model_sticky});
`ifdef REGFILE_CONFLICT_CNT_EN
      checkOutput("cmp_count", {8'b0, conflict_count}, model_count[15:0]);
`endif
    end
  end

  initial begin
    reset = 1'b1; write_en = '0; output_en = '0; wr_lane = 2'b00; reg_in = '0;

    // Reset, then one idle cycle.
    applyStimulus(8'h00, 24'h0, 2'b00, 16'h0000, 1'b1);
    applyStimulus(8'h00, 24'h0, 2'b00, 16'h0000, 1'b0);
    #2;
    checkOutput("reset_pc", pc_out, 16'h0100);
    checkOutput("reset_bus_a", bus_a, 16'h0000);
    checkOutput("reset_bus_b", bus_b, 16'h0000);
    checkOutput("reset_bus_c", bus_c, 16'h0000);
    checkOutput("reset_sticky", {15'b0, conflict_sticky}, 16'h0000);

    // Full-word write to R2, then R2 driven onto BUSA.
    applyStimulus(8'b0000_0100, 24'h0, 2'b11, 16'hBEEF, 1'b0);
    applyStimulus(8'h00, 24'h000040, 2'b00, 16'h0000, 1'b0);
    #2;
    checkOutput("r2_bus_a", bus_a, 16'hBEEF);
    checkOutput("r2_bus_b", bus_b, 16'h0000);
    checkOutput("r2_bus_c", bus_c, 16'h0000);

    // Byte lanes on R3: high lane takes the low byte of reg_in.
    applyStimulus(8'b0000_1000, 24'h0, 2'b11, 16'h1234, 1'b0);
    applyStimulus(8'b0000_1000, 24'h0, 2'b10, 16'h00AB, 1'b0);
    applyStimulus(8'b0000_1000, 24'h000800, 2'b01, 16'h00CD, 1'b0);
    #2;
    checkOutput("movh_r3", bus_c, 16'hAB34);
    applyStimulus(8'h00, 24'h000800, 2'b00, 16'h0000, 1'b0);
    #2;
    checkOutput("movl_r3", bus_c, 16'hABCD);

    // R1 and R5 both on BUSB: the lowest index wins and a conflict is raised.
    applyStimulus(8'b0000_0010, 24'h0, 2'b11, 16'h1111, 1'b0);
    applyStimulus(8'b0010_0000, 24'h0, 2'b11, 16'h5555, 1'b0);
    applyStimulus(8'h00, 24'h010010, 2'b00, 16'h0000, 1'b0);
    #2;
    checkOutput("conf_bus_b", bus_b, 16'h1111);
    checkOutput("conf_flag", {15'b0, bus_conflict}, 16'h0001);
    checkOutput("conf_sticky_pre", {15'b0, conflict_sticky}, 16'h0000);
    applyStimulus(8'h00, 24'h0, 2'b00, 16'h0000, 1'b0);
    #2;
    checkOutput("conf_sticky_post", {15'b0, conflict_sticky}, 16'h0001);
    checkOutput("conf_flag_clear", {15'b0, bus_conflict}, 16'h0000);
`ifdef REGFILE_CONFLICT_CNT_EN
    checkOutput("conf_count_1", {8'b0, conflict_count}, 16'h0001);
`endif

    // Multi-hot write, then one register shared across two buses.
    applyStimulus(8'b1100_0000, 24'h0, 2'b11, 16'h7777, 1'b0);
    applyStimulus(8'h00, 24'h440000, 2'b00, 16'h0000, 1'b0);
    #2;
    checkOutput("multi_r6", bus_a, 16'h7777);
    checkOutput("multi_r7", bus_b, 16'h7777);
    applyStimulus(8'h00, 24'h000140, 2'b00, 16'h0000, 1'b0);
    #2;
    checkOutput("share_bus_a", bus_a, 16'hBEEF);
    checkOutput("share_bus_c", bus_c, 16'hBEEF);
    checkOutput("share_no_conf", {15'b0, bus_conflict}, 16'h0000);

    // A low-lane write to the PC, then lane 00 writes nothing at all.
    applyStimulus(8'b0000_0001, 24'h0, 2'b01, 16'h00EE, 1'b0);
    applyStimulus(8'hFF, 24'h0, 2'b00, 16'hFFFF, 1'b0);
    #2;
    checkOutput("pc_movl", pc_out, 16'h01EE);
    applyStimulus(8'h00, 24'h000040, 2'b00, 16'h0000, 1'b0);
    #2;
    checkOutput("lane00_pc", pc_out, 16'h01EE);
    checkOutput("lane00_r2", bus_a, 16'hBEEF);

    // Reset wins over a PC write on the same edge.
    applyStimulus(8'b0000_0001, 24'h0, 2'b11, 16'h0042, 1'b1);
    applyStimulus(8'h00, 24'h000040, 2'b00, 16'h0000, 1'b0);
    #2;
    checkOutput("rst_wins_pc", pc_out, 16'h0100);
    checkOutput("rst_clears_r2", bus_a, 16'h0000);
    checkOutput("rst_sticky", {15'b0, conflict_sticky}, 16'h0000);

    // Hold a BUSC conflict (R1 and R2) for 300 edges.
    for (int n = 0; n < 300; n++) applyStimulus(8'h00, 24'h000120, 2'b00, 16'h0000, 1'b0);
    applyStimulus(8'h00, 24'h0, 2'b00, 16'h0000, 1'b0);
    #2;
    checkOutput("long_sticky", {15'b0, conflict_sticky}, 16'h0001);
`ifdef REGFILE_CONFLICT_CNT_EN
    checkOutput("count_saturate", {8'b0, conflict_count}, 16'h00FF);
`endif

    // No write-through: the old value is visible until the edge.
    applyStimulus(8'b0000_0100, 24'h000040, 2'b11, 16'hA5A5, 1'b0);
    #2;
    checkOutput("wt_old", bus_a, 16'h0000);
    applyStimulus(8'h00, 24'h000040, 2'b00, 16'h0000, 1'b0);
    #2;
    checkOutput("wt_new", bus_a, 16'hA5A5);

    applyStimulus(8'h00, 24'h0, 2'b00, 16'h0000, 1'b0);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_regfile.md
Name: cpu_regfile

Overview:
- Register-file and bus-fabric responder that consumes the control strobes issued by the CPU controller: per-register write enables, per-register bus output enables, and the register write-back value.
- Holds eight 16-bit registers (R0 = PC) and drives the three operand buses BUSA/BUSB/BUSC into the ALU and memory path.
- Performs byte-lane writes for MOVL/MOVH.
- Detects illegal multi-driver bus selections.

Parameters:
- WIDTH, 16, register and bus width in bits.
- NREGS, 8, number of registers; index 0 is the PC.
- RESET_PC, 16'h0000, value loaded into R0 on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- write_en  input  NREGS  one bit per register; bit i set writes R[i] at the next rising edge.
- output_en  input  3*NREGS  bit 3i drives R[i] onto BUSA, 3i+1 onto BUSB, 3i+2 onto BUSC.
- wr_lane  input  2  byte-lane mask for writes: 11 full word, 01 low byte, 10 high byte, 00 no write.
- reg_in  input  WIDTH  write-back data (ALU-OUT, memory data, or immediate).
- bus_a  output  WIDTH  BUSA value.
- bus_b  output  WIDTH  BUSB value.
- bus_c  output  WIDTH  BUSC value.
- pc_out  output  WIDTH  current R0, always visible for instruction fetch.
- bus_conflict  output  1  combinational: more than one register selected on any one bus this cycle.
- conflict_sticky  output  1  registered: set on any rising edge where bus_conflict=1; cleared only by reset.

Behaviour:
- Reset (sync, rising clk with reset=1):
  - R0 <= RESET_PC; R1..R7 <= 0; conflict_sticky <= 0.
  - Reset overrides every write in the same cycle.
- Write, at each rising edge with reset=0, for each i with write_en[i]=1:
  - wr_lane=11: R[i] <= reg_in.
  - wr_lane=01: R[i][7:0] <= reg_in[7:0]; R[i][15:8] held.
  - wr_lane=10: R[i][15:8] <= reg_in[7:0], i.e. the low byte of reg_in goes to the high lane; R[i][7:0] held.
  - wr_lane=00: no change.
- Multi-hot write_en is legal. All selected registers receive the same value and no flag is raised.
- Write latency is 1 cycle: the new value is visible on buses/pc_out immediately after the edge.
- Read path is combinational from current register state. A register written at edge N shows its old value on the buses before edge N (no write-through bypass).
- Bus mux, per bus independently:
  - 0 selects: bus = 0.
  - 1 select: bus = that register.
  - ≥2 selects: bus = lowest-index selected register, and bus_conflict=1.
- No tri-state; pure priority mux.
- A register may drive several buses simultaneously (e.g. R2 on BUSA and BUSC). This is legal and no conflict.
- pc_out = R0 unconditionally, independent of output_en.
- A write to R0 (PC) behaves exactly like any other register, including byte lanes.
- Reset asserted mid-sequence discards the pending write. The controller restarts fetch from RESET_PC.
- The controller updates strobes on the falling edge, so all inputs are stable for the rising-edge sample; no input registering in this block.

Optional Feature:
- Macro REGFILE_CONFLICT_CNT_EN.
- When defined:
  - Adds output conflict_count [7:0], counting rising edges with bus_conflict=1.
  - Saturates at 8'hFF with no wrap.
  - Reset to 0.
- When undefined: the port is absent, and no counter logic or area is used.
- conflict_sticky is present in both builds.

Test Plan:
- Reset with RESET_PC=16'h0100, then 1 idle cycle -> pc_out=16'h0100, all buses 0, conflict_sticky=0.
- write_en=8'b0000_0100, wr_lane=11, reg_in=16'hBEEF; next cycle output_en=24'h000040 (bit 6, R2 on BUSA) -> bus_a=16'hBEEF, bus_b=bus_c=0.
- R3=16'h1234, then write_en bit3 with wr_lane=10, reg_in=16'h00AB -> R3=16'hAB34. Then wr_lane=01, reg_in=16'h00CD -> R3=16'hABCD.
- R1=16'h1111, R5=16'h5555; output_en selects R1 and R5 on BUSB (bits 4 and 16) -> bus_b=16'h1111, bus_conflict=1; after edge conflict_sticky=1 (and conflict_count=1 if enabled).
- Same edge: write_en=8'b0000_0001, reg_in=16'h0042, reset=1 -> pc_out=RESET_PC after edge (reset wins).
- REGFILE_CONFLICT_CNT_EN defined: hold a BUSC conflict for 300 cycles -> conflict_count=8'hFF with no wrap; write R2 while output_en selects R2 on BUSA -> bus_a shows old value until the edge, new value after.
